dbg_host32: RTL and testbench

Host-side initiator for the 32-bit UART debug protocol. It accepts one debug command at a time on a valid/ready interface, serializes the opcode and little-endian arguments over UART with CTS flow control, and collects the 1- or 4-byte response from the target debug unit. It sits in a programmer/loader FPGA design, driving a target board's debug UART, for example to stream a program image into target memory and start the CPU.

---
 rtl/dbg_host32_if.sv | 28 ++
 rtl/dbg_host32.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_dbg_host32.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_host32_if.sv
// dbg_host32_if -- command/response handshake between a debug client and
// dbg_host32.
//   cmd_valid   : client requests a command
//   cmd_ready   : host is idle and takes the command on cmd_valid && cmd_ready
//   cmd_op      : 8-bit opcode
//   cmd_arg     : 32-bit argument, sent little-endian
//   resp_valid  : one-cycle pulse, response complete
//   resp_data   : response word (1-byte replies zero-extended)
//   resp_status : 0 ACK/data, 1 NAK, 2 timeout, 3 unexpected 1-byte value
interface dbg_host32_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;

  modport master (
    output cmd_valid, cmd_op, cmd_arg,
    input  cmd_ready, resp_valid, resp_data, resp_status
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg,
    output cmd_ready, resp_valid, resp_data, resp_status
  );
endinterface

// File: rtl/dbg_host32.sv
// dbg_host32 -- host-side initiator for the 32-bit UART debug protocol.
// Takes one command at a time, sends opcode plus little-endian argument bytes
// over UART honouring the target's CTS, and collects the 1- or 4-byte reply.
//   clk, n_reset : clock, synchronous active-low reset
//   rx, tx       : UART lines to/from the target debug unit
//   cts          : target flow control (low = accepts a byte), asynchronous
//   bus          : command/response handshake (dbg_host32_if.slave)
// Also contains uart, the 8N1 byte transceiver it drives.

// uart -- 8N1 transmitter/receiver at CLK_FREQ/UART_FREQ clocks per bit.
//   tx_write/tx_data -> tx_finished pulses when the stop bit has been sent
//   rx_ready pulses with rx_data when a frame with a valid stop bit arrives
module uart #(
  parameter int CLK_FREQ  = 12_000_000,
  parameter int UART_FREQ = 115_200
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx,
  output logic       tx,
  input  logic       tx_write,
  input  logic [7:0] tx_data,
  output logic       tx_finished,
  output logic       rx_ready,
  output logic [7:0] rx_data
);
  localparam int DIV = CLK_FREQ / UART_FREQ;
  localparam int CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic [9:0]    tx_sh_q;
  logic [3:0]    tx_bits_q, rx_bits_q;
  logic [CW-1:0] tx_cnt_q, rx_cnt_q;
  logic          tx_busy_q, tx_fin_q;
  logic          rx_meta_q, rx_s_q, rx_busy_q, rx_ready_q;
  logic [7:0]    rx_sh_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tx_sh_q   <= '1;
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
      tx_busy_q <= 1'b0;
      tx_fin_q  <= 1'b0;
    end else begin
      tx_fin_q <= 1'b0;
      if (!tx_busy_q) begin
        if (tx_write) begin
          tx_sh_q   <= {1'b1, tx_data, 1'b0};
          tx_busy_q <= 1'b1;
          tx_bits_q <= '0;
          tx_cnt_q  <= '0;
        end
      end else if (tx_cnt_q == FULL) begin
        tx_cnt_q <= '0;
        tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
        if (tx_bits_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_fin_q  <= 1'b1;
        end else begin
          tx_bits_q <= tx_bits_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  // Receiver: bit 0 is sampled half a bit after the falling edge, later bits
  // one bit apart; a high start sample is treated as a glitch.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_bits_q  <= '0;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_ready_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s_q) begin
          rx_busy_q <= 1'b1;
          rx_bits_q <= '0;
          rx_cnt_q  <= '0;
        end
      end else if (rx_cnt_q == ((rx_bits_q == 4'd0) ? HALF : FULL)) begin
        rx_cnt_q <= '0;
        if (rx_bits_q == 4'd0 && rx_s_q) begin
          rx_busy_q <= 1'b0;
        end else if (rx_bits_q == 4'd9) begin
          rx_busy_q  <= 1'b0;
          rx_ready_q <= rx_s_q;
        end else begin
          // The start bit is shifted in too; eight data shifts push it out.
          rx_sh_q   <= {rx_s_q, rx_sh_q[7:1]};
          rx_bits_q <= rx_bits_q + 4'd1;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q + 1'b1;
      end
    end
  end

  assign tx          = tx_sh_q[0];
  assign tx_finished = tx_fin_q;
  assign rx_ready    = rx_ready_q;
  assign rx_data     = rx_sh_q;
endmodule

module dbg_host32 #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int UART_FREQ      = 115_200,
  parameter int TIMEOUT_CYCLES = 12_000_000,
  parameter int CTS_GUARD      = 8
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         rx,
  output logic         tx,
  input  logic         cts,
  dbg_host32_if.slave  bus
);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GUARD_LAST = 16'(CTS_GUARD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CTS, S_SEND, S_GUARD, S_RX, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d, tx_data_q, tx_data_d, tx_byte, rx_data;
  logic [31:0] arg_q, arg_d, tmo_q, tmo_d, resp_data_q, resp_data_d;
  logic [2:0]  n_tx_q, n_tx_d, idx_q, idx_d;
  logic [1:0]  k_q, k_d, resp_status_q, resp_status_d;
  logic [15:0] guard_q, guard_d;
  logic        long_q, long_d, tx_write_q, tx_write_d, cmd_ready_q, cmd_ready_d;
  logic        cts_meta_q, cts_sync_q, tx_finished, rx_ready;

  uart #(.CLK_FREQ(CLK_FREQ), .UART_FREQ(UART_FREQ)) u_uart (
    .clk, .n_reset, .rx, .tx,
    .tx_write(tx_write_q), .tx_data(tx_data_q), .tx_finished,
    .rx_ready, .rx_data
  );

  always_comb begin
    unique case (idx_q)
      3'd0:    tx_byte = op_q;
      3'd1:    tx_byte = arg_q[7:0];
      3'd2:    tx_byte = arg_q[15:8];
      3'd3:    tx_byte = arg_q[23:16];
      default: tx_byte = arg_q[31:24];
    endcase
  end

  always_comb begin
    // NOTE: every next-state value starts from its register so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    arg_d         = arg_q;
    n_tx_d        = n_tx_q;
    long_d        = long_q;
    idx_d         = idx_q;
    k_d           = k_q;
    guard_d       = guard_q;
    tmo_d         = tmo_q;
    tx_data_d     = tx_data_q;
    tx_write_d    = 1'b0;
    resp_data_d   = resp_data_q;
    resp_status_d = resp_status_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d  = bus.cmd_op;
          arg_d = bus.cmd_arg;
          unique case (bus.cmd_op)
            8'h01, 8'h04: n_tx_d = 3'd5;
            8'h20, 8'h22: n_tx_d = 3'd2;
            default:      n_tx_d = 3'd1;
          endcase
          long_d        = (bus.cmd_op == 8'h03) || (bus.cmd_op == 8'h05);
          idx_d         = '0;
          k_d           = '0;
          tmo_d         = '0;
          resp_data_d   = '0;
          resp_status_d = 2'd0;
          state_d       = S_WAIT_CTS;
        end
      end
      S_WAIT_CTS: begin
        if (!cts_sync_q) begin
          tx_data_d  = tx_byte;
          tx_write_d = 1'b1;
          state_d    = S_SEND;
        end else if (tmo_q == TMO_LAST) begin
          resp_data_d   = '0;
          resp_status_d = 2'd2;
          state_d       = S_DONE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_SEND: begin
        // Cleared here so the counter starts fresh in whichever state follows.
        tmo_d   = '0;
        guard_d = '0;
        if (tx_finished) begin
          idx_d   = idx_q + 3'd1;
          state_d = (3'(idx_q + 3'd1) < n_tx_q) ? S_GUARD : S_RX;
        end
      end
      S_GUARD: begin
        // Lets the target raise CTS during its stop bit before it is sampled.
        tmo_d = '0;
        if (guard_q == GUARD_LAST) state_d = S_WAIT_CTS;
        else                       guard_d = guard_q + 16'd1;
      end
      S_RX: begin
        if (rx_ready) begin
          resp_data_d[{k_q, 3'b000} +: 8] = rx_data;
          tmo_d = '0;
          if (!long_q) begin
            unique case (rx_data)
              8'h01:   resp_status_d = 2'd0;
              8'h02:   resp_status_d = 2'd1;
              default: resp_status_d = 2'd3;
            endcase
            state_d = S_DONE;
          end else if (k_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          resp_data_d   = '0;
          resp_status_d = 2'd2;
          state_d       = S_DONE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;  // S_DONE: the pulse cycle itself
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      arg_q         <= '0;
      n_tx_q        <= '0;
      long_q        <= 1'b0;
      idx_q         <= '0;
      k_q           <= '0;
      guard_q       <= '0;
      tmo_q         <= '0;
      tx_data_q     <= '0;
      tx_write_q    <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
      cmd_ready_q   <= 1'b0;
      cts_meta_q    <= 1'b1;
      cts_sync_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      arg_q         <= arg_d;
      n_tx_q        <= n_tx_d;
      long_q        <= long_d;
      idx_q         <= idx_d;
      k_q           <= k_d;
      guard_q       <= guard_d;
      tmo_q         <= tmo_d;
      tx_data_q     <= tx_data_d;
      tx_write_q    <= tx_write_d;
      resp_data_q   <= resp_data_d;
      resp_status_q <= resp_status_d;
      cmd_ready_q   <= cmd_ready_d;
      cts_meta_q    <= cts;
      cts_sync_q    <= cts_meta_q;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.resp_valid  = (state_q == S_DONE);
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_status = resp_status_q;
endmodule

// File: tb/tb_dbg_host32.sv
// tb_dbg_host32 -- randomized self-checking bench for dbg_host32.
// dut_a carries the normal traffic; dut_b has a short timeout for the
// silent-target case. Both share rx/cts; only the selected one gets commands.
module tb_dbg_host32;
  localparam int CLK_FREQ  = 1_000_000;
  localparam int UART_FREQ = 100_000;
  localparam int DIV       = CLK_FREQ / UART_FREQ;
  localparam int TMO_MAIN  = 5000;
  localparam int TMO_SHORT = 1000;

  logic clk = 1'b0, n_reset = 1'b0, rx = 1'b1, cts = 1'b0, sel = 1'b0;
  logic cmd_valid = 1'b0;
  logic [7:0] cmd_op = '0;
  logic [31:0] cmd_arg = '0;
  logic tx_a, tx_b;
  int n_tests = 0, n_fail = 0, cyc = 0, t_stop = 0, rv_count = 0;
  logic [7:0] tx_q[$];
  int tx_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbg_host32_if bus_a ();
  dbg_host32_if bus_b ();
  assign bus_a.cmd_valid = cmd_valid & ~sel;
  assign bus_b.cmd_valid = cmd_valid & sel;
  assign bus_a.cmd_op = cmd_op;
  assign bus_b.cmd_op = cmd_op;
  assign bus_a.cmd_arg = cmd_arg;
  assign bus_b.cmd_arg = cmd_arg;

  dbg_host32 #(.CLK_FREQ(CLK_FREQ), .UART_FREQ(UART_FREQ),
               .TIMEOUT_CYCLES(TMO_MAIN), .CTS_GUARD(8)) dut_a (
    .clk(clk), .n_reset(n_reset), .rx(rx), .tx(tx_a), .cts(cts), .bus(bus_a));
  dbg_host32 #(.CLK_FREQ(CLK_FREQ), .UART_FREQ(UART_FREQ),
               .TIMEOUT_CYCLES(TMO_SHORT), .CTS_GUARD(8)) dut_b (
    .clk(clk), .n_reset(n_reset), .rx(rx), .tx(tx_b), .cts(cts), .bus(bus_b));

  wire        tx_mon  = sel ? tx_b : tx_a;
  wire        ready_m = sel ? bus_b.cmd_ready : bus_a.cmd_ready;
  wire        valid_m = sel ? bus_b.resp_valid : bus_a.resp_valid;
  wire [31:0] data_m  = sel ? bus_b.resp_data : bus_a.resp_data;
  wire [1:0]  stat_m  = sel ? bus_b.resp_status : bus_a.resp_status;

  always @(posedge clk) if (bus_a.resp_valid === 1'b1) rv_count <= rv_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Protocol table: bytes sent (opcode included) and reply length.
  function automatic int ref_ntx(input logic [7:0] op);
    case (op)
      8'h01, 8'h04: return 5;
      8'h20, 8'h22: return 2;
      default:      return 1;
    endcase
  endfunction

  function automatic int ref_nresp(input logic [7:0] op);
    return (op == 8'h03 || op == 8'h05) ? 4 : 1;
  endfunction

  // Target-side decoder of the host's tx line.
  initial begin
    logic [7:0] b;
    int t;
    forever begin
      @(negedge tx_mon);
      @(negedge clk);
      t = cyc;
      repeat (DIV / 2 - 1) @(negedge clk);
      if (tx_mon == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx_mon;
        end
        repeat (DIV) @(negedge clk);
        tx_q.push_back(b);
        tx_t.push_back(t);
      end
    end
  end

  // Drives start + data bits, then leaves the line at the stop level.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    t_stop = cyc;
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] op, input logic [31:0] arg,
                         input logic [31:0] reply, input int nreply,
                         input int hold_idx, input int hold_cyc);
    int ntx, nresp, tmo, bound, n, hold_start, fall, lat;
    bit held, got;
    logic [31:0] exp_data;
    logic [1:0]  exp_stat;
    logic [7:0]  eb;
    ntx   = ref_ntx(op);
    nresp = ref_nresp(op);
    tmo   = sel ? TMO_SHORT : TMO_MAIN;
    if (nreply < nresp) begin
      exp_data = 32'h0; exp_stat = 2'd2;
    end else if (nresp == 4) begin
      exp_data = reply; exp_stat = 2'd0;
    end else begin
      exp_data = {24'h0, reply[7:0]};
      exp_stat = (reply[7:0] == 8'h01) ? 2'd0 : (reply[7:0] == 8'h02) ? 2'd1 : 2'd3;
    end
    tx_q.delete();
    tx_t.delete();
    n = 0;
    while (ready_m !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready"}, {31'b0, ready_m}, 1);
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_busy"}, {31'b0, ready_m}, 0);
    bound = ntx * 12 * DIV + hold_cyc + 200;
    n = 0; held = 0; fall = 0; hold_start = 0;
    while (tx_q.size() < ntx && n < bound) begin
      @(negedge clk);
      n++;
      if (hold_idx >= 0 && !held && tx_q.size() == hold_idx) begin
        cts = 1'b1; held = 1; hold_start = cyc;
      end else if (held && cts && cyc - hold_start >= hold_cyc) begin
        cts = 1'b0; fall = cyc;
      end
    end
    cts = 1'b0;
    check({tag, "_ntx"}, tx_q.size(), ntx);
    repeat (3 * DIV) @(negedge clk);
    for (int i = 0; i < ntx && i < tx_q.size(); i++) begin
      if (i == 0) eb = op;
      else        eb = arg[8*(i-1) +: 8];
      check($sformatf("%s_tx%0d", tag, i), {24'h0, tx_q[i]}, {24'h0, eb});
    end
    if (hold_idx >= 0 && tx_t.size() > hold_idx)
      check({tag, "_cts_holdoff"}, {31'b0, fall > 0 && tx_t[hold_idx] >= fall + 2}, 1);
    for (int i = 0; i < nreply; i++) begin
      if (i > 0) repeat (2 * DIV) @(negedge clk);
      send_byte(reply[8*i +: 8]);
    end
    n = 0; got = 0;
    while (!got && n < tmo + 40 * DIV) begin
      @(negedge clk);
      n++;
      if (valid_m === 1'b1) got = 1;
    end
    lat = cyc - t_stop;
    check({tag, "_resp_valid"}, {31'b0, got}, 1);
    if (got) begin
      check({tag, "_resp_data"}, data_m, exp_data);
      check({tag, "_resp_status"}, {30'b0, stat_m}, {30'b0, exp_stat});
      if (nreply < nresp)
        check({tag, "_tmo_latency"}, {31'b0, lat >= tmo && lat <= tmo + 2 * DIV}, 1);
      else
        check({tag, "_resp_latency"}, {31'b0, lat >= 1 && lat <= 2 * DIV}, 1);
      @(negedge clk);
      check({tag, "_ready_after"}, {31'b0, ready_m}, 1);
      check({tag, "_pulse_len"}, {31'b0, valid_m}, 0);
    end
    check({tag, "_no_extra_tx"}, tx_q.size(), ntx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] known [7] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h20, 8'h21, 8'h22};
    logic [7:0] op;
    logic [31:0] reply;
    int r, n, rv0;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus_a.cmd_ready}, 0);
    check("rst_valid", {31'b0, bus_a.resp_valid}, 0);
    check("rst_data", bus_a.resp_data, 0);
    check("rst_status", {30'b0, bus_a.resp_status}, 0);
    check("rst_tx", {30'b0, tx_a, tx_b}, 32'h3);
    n_reset = 1'b1;
    @(negedge clk);
    check("rst_ready_rise", {31'b0, bus_a.cmd_ready}, 1);

    run_cmd("adr_set", 8'h01, 32'h1234_5678, 32'h01, 1, -1, 0);
    run_cmd("mem_rd", 8'h05, 32'h0, 32'hDEAD_BEEF, 4, -1, 0);
    run_cmd("cts_hold", 8'h04, $urandom, 32'h01, 1, 2, 2000);
    run_cmd("unk_nak", 8'h7F, $urandom, 32'h02, 1, -1, 0);
    run_cmd("unk_odd", 8'h7F, $urandom, 32'h55, 1, -1, 0);

    sel = 1'b1;
    run_cmd("timeout", 8'h05, 32'h0, 32'h0000_BEEF, 2, -1, 0);
    sel = 1'b0;

    // Reset in the middle of a MEM_WR argument byte.
    tx_q.delete();
    cmd_op = 8'h04; cmd_arg = $urandom; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (tx_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    check("mid_rst_progress", {31'b0, tx_q.size() >= 2}, 1);
    repeat (3 * DIV) @(negedge clk);
    rv0 = rv_count;
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_ready", {31'b0, bus_a.cmd_ready}, 0);
    check("mid_rst_valid", {31'b0, bus_a.resp_valid}, 0);
    check("mid_rst_tx", {31'b0, tx_a}, 1);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (300) @(negedge clk);
    check("mid_rst_no_resp", rv_count - rv0, 0);
    check("mid_rst_tx_idle", {31'b0, tx_a}, 1);
    run_cmd("cpu_reset", 8'h21, 32'h0, 32'h01, 1, -1, 0);

    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 7);
      if (r < 7) op = known[r];
      else begin
        op = 8'($urandom_range(0, 255));
        while (op inside {8'h01, 8'h03, 8'h04, 8'h05, 8'h20, 8'h21, 8'h22})
          op = 8'($urandom_range(0, 255));
      end
      if (ref_nresp(op) == 4) reply = $urandom;
      else begin
        r = $urandom_range(0, 2);
        reply = (r == 0) ? 32'h01 : (r == 1) ? 32'h02 : 32'($urandom_range(0, 255));
      end
      run_cmd($sformatf("rnd%0d_op%02h", it, op), op, $urandom, reply,
              ref_nresp(op), -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
